// File: rtl/fifo_flex_if.sv
// fifo_flex_if: handshake bundle between a FIFO producer/consumer (master) and fifo_flex (slave).
//
// Signals
//   flush        master->slave  synchronous clear of contents, pointers and count
//   wr_en, din   master->slave  write request and write data
//   rd_en        master->slave  read request (pop acknowledge in FWFT mode)
//   clr_err      master->slave  synchronous clear of the sticky error flags
//   dout         slave->master  read data
//   full, almost_full, empty, almost_empty, count   slave->master  occupancy status
//   overflow, underflow                             slave->master  sticky error flags
interface fifo_flex_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 32
) ();
    localparam int unsigned CNT_WIDTH = $clog2(DEPTH + 1);

    logic                 flush;
    logic                 wr_en;
    logic [WIDTH-1:0]     din;
    logic                 rd_en;
    logic                 clr_err;
    logic [WIDTH-1:0]     dout;
    logic                 full;
    logic                 almost_full;
    logic                 empty;
    logic                 almost_empty;
    logic [CNT_WIDTH-1:0] count;
    logic                 overflow;
    logic                 underflow;

    modport master (
        output flush, wr_en, din, rd_en, clr_err,
        input  dout, full, almost_full, empty, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  flush, wr_en, din, rd_en, clr_err,
        output dout, full, almost_full, empty, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/fifo_flex.sv
// fifo_flex: parametrised single-clock FIFO for any DEPTH >= 2 (not only powers of two).
//
// Occupancy is tracked in a dedicated count register; full/empty/almost flags decode from it.
// Sticky overflow/underflow record rejected writes/reads until clr_err or reset.
// flush synchronously empties the FIFO without touching the error flags.
//
// Compile-time option
//   FIFO_FWFT_EN  defined   : first-word fall-through, dout shows the head entry while not empty
//                 undefined : registered output, an accepted read loads dout on its edge
//
// Ports
//   clk_i   clock, all state changes on the rising edge
//   rst_ni  asynchronous active-low reset
//   bus     fifo_flex_if slave modport (data, handshake, status and error flags)
module fifo_flex #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned AF_LEVEL = DEPTH - 2,
    parameter int unsigned AE_LEVEL = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    fifo_flex_if.slave  bus
);
    localparam int unsigned CNT_WIDTH = $clog2(DEPTH + 1);
    localparam int unsigned PTR_WIDTH = $clog2(DEPTH);

    localparam logic [CNT_WIDTH-1:0] CntFull = CNT_WIDTH'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] CntAf   = CNT_WIDTH'(AF_LEVEL);
    localparam logic [CNT_WIDTH-1:0] CntAe   = CNT_WIDTH'(AE_LEVEL);
    localparam logic [PTR_WIDTH-1:0] PtrLast = PTR_WIDTH'(DEPTH - 1);

    // Explicit wrap at DEPTH-1 so non-power-of-two depths never index past the array.
    function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
        return (p == PtrLast) ? '0 : p + PTR_WIDTH'(1);
    endfunction

    logic [WIDTH-1:0]     mem_q [DEPTH];
    logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 overflow_q, overflow_d;
    logic                 underflow_q, underflow_d;

    logic full, empty;
    logic wr_acc, rd_acc;

    assign full   = (count_q == CntFull);
    assign empty  = (count_q == '0);
    // Acceptance uses pre-edge state only: a read from a full FIFO does not free a slot
    // for a same-cycle write, and a write to an empty FIFO is not bypassed to the read.
    assign wr_acc = bus.wr_en && !full;
    assign rd_acc = bus.rd_en && !empty;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (bus.clr_err) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end

        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (rd_acc) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + CNT_WIDTH'(1);
                2'b01:   count_d = count_q - CNT_WIDTH'(1);
                default: count_d = count_q;
            endcase
            // Setting wins over a coincident clr_err.
            if (bus.wr_en && full) begin
                overflow_d = 1'b1;
            end
            if (bus.rd_en && empty) begin
                underflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately not reset; stale entries are unreachable once pointers clear.
    always_ff @(posedge clk_i) begin
        if (!bus.flush && wr_acc) begin
            mem_q[wr_ptr_q] <= bus.din;
        end
    end

`ifdef FIFO_FWFT_EN
    assign bus.dout = mem_q[rd_ptr_q];
`else
    logic [WIDTH-1:0] dout_q, dout_d;

    always_comb begin
        dout_d = dout_q;
        if (bus.flush) begin
            dout_d = '0;
        end else if (rd_acc) begin
            dout_d = mem_q[rd_ptr_q];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dout_q <= '0;
        end else begin
            dout_q <= dout_d;
        end
    end

    assign bus.dout = dout_q;
`endif

    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (count_q >= CntAf);
    assign bus.almost_empty = (count_q <= CntAe);
    assign bus.count        = count_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

    a_count_bound : assert property (@(posedge clk_i) disable iff (!rst_ni)
        count_q <= CntFull)
        else $error("fifo_flex: count exceeded DEPTH");

    a_ptr_bound : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (wr_ptr_q <= PtrLast) && (rd_ptr_q <= PtrLast))
        else $error("fifo_flex: pointer outside 0..DEPTH-1");

endmodule

// File: tb/tb_fifo_flex.sv
// Directed self-checking bench for fifo_flex. Works in both read modes (FIFO_FWFT_EN).
// u_dut_a: DEPTH=32, AF_LEVEL=30, AE_LEVEL=2. u_dut_b: DEPTH=5 for pointer-wrap checks.
module tb_fifo_flex;
    logic clk;
    logic rst_n;

    int checks;
    int errors;

    fifo_flex_if #(.WIDTH(8), .DEPTH(32)) bus_a ();
    fifo_flex_if #(.WIDTH(8), .DEPTH(5))  bus_b ();

    fifo_flex #(.WIDTH(8), .DEPTH(32), .AF_LEVEL(30), .AE_LEVEL(2)) u_dut_a (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus_a)
    );

    fifo_flex #(.WIDTH(8), .DEPTH(5)) u_dut_b (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; return 1 time unit later so outputs are settled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus_a.flush = 0; bus_a.wr_en = 0; bus_a.rd_en = 0; bus_a.clr_err = 0; bus_a.din = '0;
        bus_b.flush = 0; bus_b.wr_en = 0; bus_b.rd_en = 0; bus_b.clr_err = 0; bus_b.din = '0;
    endtask

    task automatic test_reset();
        checks++;
        if (bus_a.empty !== 1'b1 || bus_a.full !== 1'b0 || bus_a.almost_empty !== 1'b1 ||
            bus_a.almost_full !== 1'b0 || bus_a.count !== 6'd0 || bus_a.overflow !== 1'b0 ||
            bus_a.underflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: e=%b f=%b ae=%b af=%b cnt=%0d ov=%b un=%b, need 1 0 1 0 0 0 0",
                     bus_a.empty, bus_a.full, bus_a.almost_empty, bus_a.almost_full,
                     bus_a.count, bus_a.overflow, bus_a.underflow);
        end
`ifndef FIFO_FWFT_EN
        checks++;
        if (bus_a.dout !== 8'h00) begin
            errors++;
            $display("FAIL reset_dout: got %h need 00", bus_a.dout);
        end
`endif
        checks++;
        if (bus_b.empty !== 1'b1 || bus_b.count !== 3'd0) begin
            errors++;
            $display("FAIL reset_b: empty=%b count=%0d need 1 0", bus_b.empty, bus_b.count);
        end
    endtask

    task automatic test_order();
        logic [7:0] got;
        for (int i = 1; i <= 5; i++) begin
            bus_a.wr_en = 1; bus_a.din = 8'(i);
            tick();
            checks++;
            if (bus_a.count !== 6'(i) || bus_a.empty !== 1'b0) begin
                errors++;
                $display("FAIL order_wr_count: got %0d empty=%b need %0d empty=0",
                         bus_a.count, bus_a.empty, i);
            end
        end
        bus_a.wr_en = 0;
        for (int k = 1; k <= 5; k++) begin
            bus_a.rd_en = 1;
`ifdef FIFO_FWFT_EN
            got = bus_a.dout;
`endif
            tick();
`ifndef FIFO_FWFT_EN
            got = bus_a.dout;
`endif
            checks++;
            if (got !== 8'(k) || bus_a.count !== 6'(5 - k)) begin
                errors++;
                $display("FAIL order_rd: dout=%h count=%0d need %h %0d",
                         got, bus_a.count, 8'(k), 5 - k);
            end
        end
        bus_a.rd_en = 0;
        checks++;
        if (bus_a.empty !== 1'b1) begin
            errors++;
            $display("FAIL order_empty: got %b need 1", bus_a.empty);
        end
    endtask

    // DEPTH=5: 4 writes, 8 write+read cycles, 4 reads; 12 entries cross the wrap twice.
    task automatic test_wrap();
        logic [7:0] got;
        int rd_idx;
        rd_idx = 0;
        for (int i = 0; i < 12; i++) begin
            bus_b.wr_en = 1; bus_b.din = 8'(8'h10 + i);
            bus_b.rd_en = (i >= 4);
`ifdef FIFO_FWFT_EN
            got = bus_b.dout;
`endif
            tick();
`ifndef FIFO_FWFT_EN
            got = bus_b.dout;
`endif
            if (i >= 4) begin
                checks++;
                if (got !== 8'(8'h10 + rd_idx)) begin
                    errors++;
                    $display("FAIL wrap_data: got %h need %h", got, 8'(8'h10 + rd_idx));
                end
                rd_idx++;
            end
            checks++;
            if (bus_b.count !== 3'((i < 4) ? i + 1 : 4)) begin
                errors++;
                $display("FAIL wrap_count: got %0d need %0d", bus_b.count, (i < 4) ? i + 1 : 4);
            end
        end
        bus_b.wr_en = 0;
        for (int k = 0; k < 4; k++) begin
            bus_b.rd_en = 1;
`ifdef FIFO_FWFT_EN
            got = bus_b.dout;
`endif
            tick();
`ifndef FIFO_FWFT_EN
            got = bus_b.dout;
`endif
            checks++;
            if (got !== 8'(8'h10 + rd_idx) || bus_b.count !== 3'(3 - k)) begin
                errors++;
                $display("FAIL wrap_drain: dout=%h count=%0d need %h %0d",
                         got, bus_b.count, 8'(8'h10 + rd_idx), 3 - k);
            end
            rd_idx++;
        end
        bus_b.rd_en = 0;
    endtask

    task automatic test_flags_ramp();
        for (int i = 1; i <= 32; i++) begin
            bus_a.wr_en = 1; bus_a.din = 8'(8'h40 + i);
            tick();
            checks++;
            if (bus_a.count !== 6'(i) || bus_a.almost_empty !== (i <= 2) ||
                bus_a.almost_full !== (i >= 30) || bus_a.full !== (i == 32)) begin
                errors++;
                $display("FAIL ramp_flags: cnt=%0d ae=%b af=%b f=%b need cnt=%0d ae=%b af=%b f=%b",
                         bus_a.count, bus_a.almost_empty, bus_a.almost_full, bus_a.full,
                         i, i <= 2, i >= 30, i == 32);
            end
        end
        bus_a.wr_en = 0;
    endtask

    task automatic test_overflow();
        logic [7:0] got;
        bus_a.wr_en = 1; bus_a.rd_en = 1; bus_a.din = 8'hEE;
`ifdef FIFO_FWFT_EN
        got = bus_a.dout;
`endif
        tick();
`ifndef FIFO_FWFT_EN
        got = bus_a.dout;
`endif
        bus_a.wr_en = 0; bus_a.rd_en = 0;
        checks++;
        if (bus_a.count !== 6'd31 || bus_a.overflow !== 1'b1 || bus_a.underflow !== 1'b0 ||
            bus_a.full !== 1'b0) begin
            errors++;
            $display("FAIL overflow_set: cnt=%0d ov=%b un=%b f=%b need 31 1 0 0",
                     bus_a.count, bus_a.overflow, bus_a.underflow, bus_a.full);
        end
        checks++;
        if (got !== 8'h41) begin
            errors++;
            $display("FAIL overflow_rd_data: got %h need 41", got);
        end
        tick();
        checks++;
        if (bus_a.overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_sticky: got %b need 1", bus_a.overflow);
        end
        bus_a.clr_err = 1;
        tick();
        bus_a.clr_err = 0;
        checks++;
        if (bus_a.overflow !== 1'b0 || bus_a.count !== 6'd31) begin
            errors++;
            $display("FAIL overflow_clr: ov=%b cnt=%0d need 0 31", bus_a.overflow, bus_a.count);
        end
    endtask

    task automatic test_flush_basic();
        bus_a.flush = 1;
        tick();
        bus_a.flush = 0;
        checks++;
        if (bus_a.count !== 6'd0 || bus_a.empty !== 1'b1) begin
            errors++;
            $display("FAIL flush_basic: cnt=%0d empty=%b need 0 1", bus_a.count, bus_a.empty);
        end
    endtask

    task automatic test_underflow();
        logic [7:0] got;
        bus_a.wr_en = 1; bus_a.rd_en = 1; bus_a.din = 8'hAA;
        tick();
        bus_a.wr_en = 0; bus_a.rd_en = 0;
        checks++;
        if (bus_a.count !== 6'd1 || bus_a.underflow !== 1'b1 || bus_a.overflow !== 1'b0) begin
            errors++;
            $display("FAIL underflow_set: cnt=%0d un=%b ov=%b need 1 1 0",
                     bus_a.count, bus_a.underflow, bus_a.overflow);
        end
        bus_a.rd_en = 1;
`ifdef FIFO_FWFT_EN
        got = bus_a.dout;
`endif
        tick();
`ifndef FIFO_FWFT_EN
        got = bus_a.dout;
`endif
        bus_a.rd_en = 0;
        checks++;
        if (got !== 8'hAA || bus_a.empty !== 1'b1) begin
            errors++;
            $display("FAIL underflow_data: dout=%h empty=%b need aa 1", got, bus_a.empty);
        end
    endtask

    task automatic test_flush_priority();
        for (int i = 0; i < 7; i++) begin
            bus_a.wr_en = 1; bus_a.din = 8'(8'h60 + i);
            tick();
        end
        checks++;
        if (bus_a.count !== 6'd7) begin
            errors++;
            $display("FAIL flush_pre_count: got %0d need 7", bus_a.count);
        end
        bus_a.flush = 1; bus_a.wr_en = 1; bus_a.din = 8'h77;
        tick();
        bus_a.flush = 0; bus_a.wr_en = 0;
        checks++;
        if (bus_a.count !== 6'd0 || bus_a.empty !== 1'b1 || bus_a.underflow !== 1'b1 ||
            bus_a.overflow !== 1'b0) begin
            errors++;
            $display("FAIL flush_prio: cnt=%0d e=%b un=%b ov=%b need 0 1 1 0",
                     bus_a.count, bus_a.empty, bus_a.underflow, bus_a.overflow);
        end
`ifndef FIFO_FWFT_EN
        checks++;
        if (bus_a.dout !== 8'h00) begin
            errors++;
            $display("FAIL flush_dout: got %h need 00", bus_a.dout);
        end
`endif
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) begin
            bus_a.wr_en = 1; bus_a.din = 8'(8'h90 + i);
            tick();
        end
        // A read sets registered dout to a nonzero value before the reset.
        bus_a.wr_en = 1; bus_a.rd_en = 1; bus_a.din = 8'h93;
        tick();
        // Mid-cycle, between edges, with the burst still requesting.
        #2;
        rst_n = 0;
        #1;
        checks++;
        if (bus_a.count !== 6'd0 || bus_a.empty !== 1'b1 || bus_a.full !== 1'b0 ||
            bus_a.almost_empty !== 1'b1 || bus_a.almost_full !== 1'b0 ||
            bus_a.overflow !== 1'b0 || bus_a.underflow !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: cnt=%0d e=%b f=%b ae=%b af=%b ov=%b un=%b",
                     bus_a.count, bus_a.empty, bus_a.full, bus_a.almost_empty,
                     bus_a.almost_full, bus_a.overflow, bus_a.underflow);
        end
`ifndef FIFO_FWFT_EN
        checks++;
        if (bus_a.dout !== 8'h00) begin
            errors++;
            $display("FAIL async_reset_dout: got %h need 00", bus_a.dout);
        end
`endif
        idle_inputs();
        #1;
        rst_n = 1;
        tick();
        checks++;
        if (bus_a.count !== 6'd0 || bus_a.empty !== 1'b1) begin
            errors++;
            $display("FAIL post_reset: cnt=%0d empty=%b need 0 1", bus_a.count, bus_a.empty);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 0;
        idle_inputs();
        #23;
        rst_n = 1;
        tick();
        test_reset();
        test_order();
        test_wrap();
        test_flags_ramp();
        test_overflow();
        test_flush_basic();
        test_underflow();
        test_flush_priority();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog: the directed sequence is a few hundred cycles.
    initial begin
        #100000;
        $display("FAIL watchdog: timeout after %0t, need completion", $time);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/fifo_flex.md
# fifo_flex

Parametrised single-clock FIFO and successor to the basic 8x32 FIFO used in the Ising datapath between the spin-update engine and the host/readout side. It accepts any depth (not only powers of two) and reports occupancy with programmable almost-full/almost-empty flags. It also provides sticky overflow/underflow error flags and a synchronous flush. Read mode is either registered-output (one-cycle read latency) or first-word fall-through, selected at compile time.

## Interface
- WIDTH, 8: data word width in bits, ≥1.
- DEPTH, 32: number of entries, any integer ≥2.
- AF_LEVEL, DEPTH-2: almost_full asserts when count ≥ AF_LEVEL; range 1..DEPTH.
- AE_LEVEL, 2: almost_empty asserts when count ≤ AE_LEVEL; range 0..DEPTH-1.
- CNT_WIDTH, $clog2(DEPTH+1): width of count. Derived; never overridden.
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  reset; asynchronous, active-low (asserted when 0).
- flush  in  1  synchronous clear of contents, pointers and count.
- wr_en  in  1  write request.
- din  in  WIDTH  write data.
- full  out  1  count == DEPTH.
- almost_full  out  1  count ≥ AF_LEVEL.
- rd_en  in  1  read request (acknowledge in FWFT mode).
- dout  out  WIDTH  read data.
- empty  out  1  count == 0.
- almost_empty  out  1  count ≤ AE_LEVEL.
- count  out  CNT_WIDTH  current occupancy, 0..DEPTH.
- clr_err  in  1  synchronous clear of overflow/underflow.
- overflow  out  1  sticky: a write was rejected.
- underflow  out  1  sticky: a read was rejected.

## Operation
- Storage is a DEPTH-entry register array. wr_ptr and rd_ptr are each $clog2(DEPTH) bits wide and wrap explicitly from DEPTH-1 to 0; there is no binary rollover, so non-power-of-two depths work. A separate count register holds occupancy.
- full, empty, almost_full and almost_empty decode combinationally from the registered count.
- Write accept = wr_en && !full. Read accept = rd_en && !empty. Both use pre-edge state.
- Both accepted in the same cycle: both pointers advance and count is unchanged.
- Full with wr_en and rd_en both high: the read is accepted and the write is rejected (overflow sets). The freed slot is not reused in the same cycle.
- Empty with wr_en and rd_en both high: the write is accepted and the read is rejected (underflow sets). No bypass path.
- count: +1 on write only, -1 on read only, otherwise unchanged. It never exceeds DEPTH and never goes below 0.
- overflow sets on wr_en && full. underflow sets on rd_en && empty. Both hold until clr_err or reset; if set and clr_err coincide, set wins.
- flush has priority over wr_en and rd_en in the same cycle. It zeroes both pointers, count and the registered dout. It leaves overflow/underflow unchanged and sets neither.
- Reset (rst=0, asynchronous) clears pointers, count, dout, overflow and underflow to 0 immediately. Array contents are not reset. Reset mid-transfer discards all queued data.

## Timing
- Reset values: full=0, almost_full=(AF_LEVEL==0 ? 1 : 0), empty=1, almost_empty=1, count=0, dout=0, overflow=0, underflow=0.
- Write-to-empty-deassert: 1 cycle (empty falls after the edge that accepts the write).
- Registered mode: an accepted read loads dout on that edge; data is valid the cycle after rd_en. dout holds its value when no read is accepted.
- Flags and count reflect every accepted operation one edge after the request.
- Throughput: one write and one read per cycle, sustained.

## Configuration
- FIFO_FWFT_EN defined: first-word fall-through.
  - dout combinationally shows the head entry whenever empty=0; rd_en pops it.
  - Data is visible on dout in the cycle after the write edge.
  - dout is don't-care while empty.
- FIFO_FWFT_EN undefined: registered-output mode as described in Timing.
- All other behaviour is identical in both modes.

## Test plan
- Reset then write 0x01..0x05 on consecutive cycles, then read 5 → dout 0x01..0x05 in order, count steps 5→0, empty=1 at end. Run in both modes; registered mode lags by one cycle.
- DEPTH=5: perform 12 writes interleaved with reads → order preserved across pointer wrap, count never exceeds 5.
- Fill to DEPTH=32, then assert wr_en and rd_en together → read accepted, write dropped, count=31, overflow=1. Then pulse clr_err → overflow=0.
- Empty FIFO with rd_en and wr_en together, din=0xAA → count=1, underflow=1. Next read returns 0xAA.
- AF_LEVEL=30, AE_LEVEL=2: ramp count 0→32 → almost_empty deasserts at count=3, almost_full asserts at count=30.
- At count=7, assert flush together with wr_en → count=0, empty=1, dout=0, sticky flags unchanged. Then drop rst asynchronously mid-burst → all outputs at reset values before the next clock edge.
